// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: loads a parallel pattern and shifts it out one bit per
// valid/ready transfer, tracking ones-count (saturating at 2) and zero parity
// of the transferred bits. At completion it reports the verdict expected from
// the sequence recognizer: at least two 1s and an odd number of 0s.
// Optional build macro: SEQ_TX_MSB_FIRST_EN (send bit len-1 first, down to bit 0).
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    len,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             done,
  output logic             expect_accept
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    rem;
  logic [1:0]       ones_cnt;
  logic             zero_par;

  logic             xfer;
  logic [LW-1:0]    clen;
  logic [1:0]       ones_nxt;
  logic             zpar_nxt;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shifted;
  logic             first_bit;
  logic             next_bit;

  // Clamped length, transfer strobe, counter look-ahead and shift ordering
  always_comb begin
    clen     = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
    xfer     = bit_valid & bit_ready;
    ones_nxt = ones_cnt;
    if (bit_out && (ones_cnt != 2'd2)) ones_nxt = ones_cnt + 2'd1;
    zpar_nxt = zero_par ^ ~bit_out;
`ifdef SEQ_TX_MSB_FIRST_EN
    // Left-align the pattern so bit len-1 sits at the top; unsent upper bits
    // of data fall off the end and are never transmitted.
    load_word = data << (WIDTH - 32'(clen));
    first_bit = load_word[WIDTH-1];
    shifted   = shreg << 1;
    next_bit  = shreg[WIDTH-2];
`else
    load_word = data;
    first_bit = data[0];
    shifted   = shreg >> 1;
    next_bit  = shreg[1];
`endif
  end

  // Control FSM with registered outputs; DONE accepts a load just like IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      rem           <= '0;
      ones_cnt      <= '0;
      zero_par      <= 1'b0;
      busy          <= 1'b0;
      bit_out       <= 1'b0;
      bit_valid     <= 1'b0;
      done          <= 1'b0;
      expect_accept <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            shreg         <= load_word;
            rem           <= clen;
            ones_cnt      <= '0;
            zero_par      <= 1'b0;
            expect_accept <= 1'b0;
            if (clen == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              bit_valid <= 1'b0;
              bit_out   <= 1'b0;
            end else begin
              state     <= SHIFT;
              busy      <= 1'b1;
              bit_valid <= 1'b1;
              bit_out   <= first_bit;
            end
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shreg    <= shifted;
            rem      <= rem - LW'(1);
            ones_cnt <= ones_nxt;
            zero_par <= zpar_nxt;
            bit_out  <= next_bit;
            if (rem == LW'(1)) begin
              // Verdict uses look-ahead counters so the final bit is included
              state         <= DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              bit_valid     <= 1'b0;
              bit_out       <= 1'b0;
              expect_accept <= (ones_nxt == 2'd2) & zpar_nxt;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bit_valid <= 1'b0;
          bit_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule
